// File: rtl/spram_dot_reader.sv
// Read-side master for the dual-read-port weight/activation RAM: streams len
// operand pairs, accumulates their signed products with saturation, hands off the sum.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing one address pair per cycle
// DRAIN | accumulating the last word returned by the RAM
// HOLD  | result_valid high until the consumer takes the result
module spram_dot_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 15,
  parameter int LEN_WIDTH  = 10,
  parameter int ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] w_base,
  input  logic [ADDR_WIDTH-1:0] x_base,
  input  logic [LEN_WIDTH-1:0]  len,
  output logic                  busy,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [ADDR_WIDTH-1:0] ram_address_a,
  output logic [ADDR_WIDTH-1:0] ram_address_b,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe_a,
  output logic                  ram_oe_b,
  input  logic [DATA_WIDTH-1:0] ram_data_a,
  input  logic [DATA_WIDTH-1:0] ram_data_b
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_a, addr_b;
  logic [LEN_WIDTH-1:0]  cnt;
  logic                  data_vld;
  logic [ACC_WIDTH-1:0]  acc, acc_sat, acc_nxt;
  logic [ACC_WIDTH-1:0]  result_r;
  logic                  result_valid_r;

  logic signed [PW-1:0]  a_ext, b_ext, prod;
  logic [ACC_WIDTH:0]    sum;

  assign a_ext = {{DATA_WIDTH{ram_data_a[DATA_WIDTH-1]}}, ram_data_a};
  assign b_ext = {{DATA_WIDTH{ram_data_b[DATA_WIDTH-1]}}, ram_data_b};
  assign prod  = a_ext * b_ext;

  // One guard bit: differing top two bits of the sum means overflow.
  assign sum = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH+1-PW){prod[PW-1]}}, prod};

  always_comb begin
    acc_sat = sum[ACC_WIDTH-1:0];
    if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1])
      acc_sat = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  end

  assign acc_nxt = data_vld ? acc_sat : acc;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? HOLD : FETCH;
      FETCH:   if (cnt == LEN_WIDTH'(1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = HOLD;
      HOLD:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      addr_a         <= '0;
      addr_b         <= '0;
      cnt            <= '0;
      data_vld       <= 1'b0;
      acc            <= '0;
      result_r       <= '0;
      result_valid_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_vld <= (state == FETCH);
      case (state)
        IDLE: begin
          if (start) begin
            addr_a <= w_base;
            addr_b <= x_base;
            cnt    <= len;
            acc    <= '0;
            if (len == '0) begin
              result_r       <= '0;
              result_valid_r <= 1'b1;
            end
          end
        end
        FETCH: begin
          addr_a <= addr_a + ADDR_WIDTH'(1);
          addr_b <= addr_b + ADDR_WIDTH'(1);
          cnt    <= cnt - LEN_WIDTH'(1);
          acc    <= acc_nxt;
        end
        DRAIN: begin
          acc            <= acc_nxt;
          result_r       <= acc_nxt;
          result_valid_r <= 1'b1;
        end
        HOLD: begin
          if (result_ready) result_valid_r <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // The RAM zeroes its data unless selected, so DRAIN keeps the enables up.
  assign ram_cs        = (state == FETCH) || (state == DRAIN);
  assign ram_oe_a      = ram_cs;
  assign ram_oe_b      = ram_cs;
  assign ram_we        = 1'b0;
  assign ram_address_a = addr_a;
  assign ram_address_b = addr_b;
  assign busy          = (state != IDLE);
  assign result        = result_r;
  assign result_valid  = result_valid_r;

endmodule

// File: tb/tb_spram_dot_reader.sv
// Bench for spram_dot_reader: default 24-bit accumulator plus a 16-bit copy run in
// lockstep to exercise clamping; RAM modelled with one-cycle read latency and gating.
module tb_spram_dot_reader;

  localparam int DW = 8;
  localparam int AW = 15;
  localparam int LW = 10;

  logic          clk, rst, start, result_ready;
  logic [AW-1:0] w_base, x_base;
  logic [LW-1:0] len;

  logic          busy, result_valid, ram_cs, ram_we, ram_oe_a, ram_oe_b;
  logic [23:0]   result;
  logic [AW-1:0] ram_address_a, ram_address_b;
  logic [DW-1:0] ram_data_a, ram_data_b, qa, qb;

  logic          busy_16, result_valid_16, ram_cs_16, ram_we_16, ram_oe_a_16, ram_oe_b_16;
  logic [15:0]   result_16;
  logic [AW-1:0] ram_address_a_16, ram_address_b_16;
  logic [DW-1:0] ram_data_a_16, ram_data_b_16, qa_16, qb_16;

  logic [7:0]    mem [0:32767];

  int        n_vec = 0;
  int        n_err = 0;
  longint    exp_q[$];
  longint    exp16_q[$];
  int        obs_a[$];
  int        obs_b[$];
  bit        we_bad;

  spram_dot_reader dut (
    .clk(clk), .rst(rst), .start(start), .w_base(w_base), .x_base(x_base), .len(len),
    .busy(busy), .result(result), .result_valid(result_valid), .result_ready(result_ready),
    .ram_address_a(ram_address_a), .ram_address_b(ram_address_b), .ram_cs(ram_cs),
    .ram_we(ram_we), .ram_oe_a(ram_oe_a), .ram_oe_b(ram_oe_b),
    .ram_data_a(ram_data_a), .ram_data_b(ram_data_b)
  );

  spram_dot_reader #(.ACC_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .w_base(w_base), .x_base(x_base), .len(len),
    .busy(busy_16), .result(result_16), .result_valid(result_valid_16),
    .result_ready(result_ready),
    .ram_address_a(ram_address_a_16), .ram_address_b(ram_address_b_16), .ram_cs(ram_cs_16),
    .ram_we(ram_we_16), .ram_oe_a(ram_oe_a_16), .ram_oe_b(ram_oe_b_16),
    .ram_data_a(ram_data_a_16), .ram_data_b(ram_data_b_16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    qa    <= mem[ram_address_a];
    qb    <= mem[ram_address_b];
    qa_16 <= mem[ram_address_a_16];
    qb_16 <= mem[ram_address_b_16];
  end
  assign ram_data_a    = (ram_cs && ram_oe_a && !ram_we) ? qa : '0;
  assign ram_data_b    = (ram_cs && ram_oe_b && !ram_we) ? qb : '0;
  assign ram_data_a_16 = (ram_cs_16 && ram_oe_a_16 && !ram_we_16) ? qa_16 : '0;
  assign ram_data_b_16 = (ram_cs_16 && ram_oe_b_16 && !ram_we_16) ? qb_16 : '0;

  function automatic longint model(input int wb, input int xb, input int n, input int aw);
    longint acc = 0;
    longint hi  = (longint'(1) << (aw - 1)) - 1;
    longint lo  = -(longint'(1) << (aw - 1));
    for (int i = 0; i < n; i++) begin
      acc += longint'($signed(mem[(wb + i) & 32'h7FFF])) *
             longint'($signed(mem[(xb + i) & 32'h7FFF]));
      if (acc > hi) acc = hi;
      else if (acc < lo) acc = lo;
    end
    return acc;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int a, input int v);
    mem[a & 32'h7FFF] = v[7:0];
  endtask

  task automatic start_op(input int wb, input int xb, input int n, input bit push);
    w_base = AW'(wb);
    x_base = AW'(xb);
    len    = LW'(n);
    start  = 1'b1;
    if (push) begin
      exp_q.push_back(model(wb, xb, n, 24));
      exp16_q.push_back(model(wb, xb, n, 16));
    end
    obs_a.delete();
    obs_b.delete();
    we_bad = 1'b0;
    tick();
    start  = 1'b0;
    w_base = ~w_base;
    x_base = x_base + AW'(77);
    len    = LW'(n + 3);
  endtask

  // Returns the cycle (start cycle = 0) at which result_valid was first seen.
  task automatic wait_valid(output int cyc, output bit to);
    cyc = 1;
    while (!result_valid && cyc < 200) begin
      if (ram_cs) begin
        obs_a.push_back(int'(ram_address_a));
        obs_b.push_back(int'(ram_address_b));
      end
      if (ram_we || ram_we_16) we_bad = 1'b1;
      tick();
      cyc++;
    end
    to = !result_valid;
  endtask

  task automatic handshake;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({busy, result_valid, ram_cs, ram_oe_a, ram_oe_b, ram_we} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl got busy/vld/cs/oea/oeb/we=%b want 000000",
               {busy, result_valid, ram_cs, ram_oe_a, ram_oe_b, ram_we});
    end
    n_vec++;
    if (result !== 24'h0 || ram_address_a !== '0 || ram_address_b !== '0) begin
      n_err++;
      $display("FAIL reset_data got result=%h addr_a=%h addr_b=%h want 0/0/0",
               result, ram_address_a, ram_address_b);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int cyc;
    bit to;
    longint e, e16;
    put(32'h10, 1);  put(32'h11, -2); put(32'h12, 3);  put(32'h13, 4);
    put(32'h200, 5); put(32'h201, 6); put(32'h202, -7); put(32'h203, 8);
    start_op(32'h10, 32'h200, 4, 1'b1);
    wait_valid(cyc, to);
    e = exp_q.pop_front();
    e16 = exp16_q.pop_front();
    n_vec++;
    if (to || cyc != 6) begin
      n_err++;
      $display("FAIL basic_latency got cycle=%0d timeout=%0d want cycle=6", cyc, to);
    end
    n_vec++;
    if (longint'($signed(result)) != e || e != 4) begin
      n_err++;
      $display("FAIL basic_result got %0d want %0d (4)", $signed(result), e);
    end
    n_vec++;
    if (longint'($signed(result_16)) != e16) begin
      n_err++;
      $display("FAIL basic_result16 got %0d want %0d", $signed(result_16), e16);
    end
    n_vec++;
    if (obs_a.size() != 5 || we_bad) begin
      n_err++;
      $display("FAIL basic_cs_cycles got %0d cs cycles we_bad=%0d want 5 and 0",
               obs_a.size(), we_bad);
    end
    for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
      n_vec++;
      if (obs_a[i] != 32'h10 + i || obs_b[i] != 32'h200 + i) begin
        n_err++;
        $display("FAIL basic_addr[%0d] got a=%h b=%h want a=%h b=%h",
                 i, obs_a[i], obs_b[i], 32'h10 + i, 32'h200 + i);
      end
    end
    handshake();
    n_vec++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || longint'($signed(result)) != e) begin
      n_err++;
      $display("FAIL basic_release got vld=%b busy=%b result=%0d want 0/0/%0d",
               result_valid, busy, $signed(result), e);
    end
  endtask

  task automatic test_extremes;
    int cyc;
    bit to;
    longint e, e16;
    put(32'h40, -128);
    put(32'h240, -128);
    start_op(32'h40, 32'h240, 1, 1'b1);
    wait_valid(cyc, to);
    e = exp_q.pop_front();
    e16 = exp16_q.pop_front();
    n_vec++;
    if (to || cyc != 3 || longint'($signed(result)) != e || e != 16384) begin
      n_err++;
      $display("FAIL len1_min_min got cycle=%0d result=%0d want cycle=3 result=%0d",
               cyc, $signed(result), e);
    end
    n_vec++;
    if (longint'($signed(result_16)) != e16) begin
      n_err++;
      $display("FAIL len1_min_min16 got %0d want %0d", $signed(result_16), e16);
    end
    handshake();
    start_op(32'h40, 32'h240, 0, 1'b1);
    wait_valid(cyc, to);
    e = exp_q.pop_front();
    void'(exp16_q.pop_front());
    n_vec++;
    if (to || cyc != 1 || result !== 24'h0 || e != 0) begin
      n_err++;
      $display("FAIL len0 got cycle=%0d result=%h want cycle=1 result=000000", cyc, result);
    end
    n_vec++;
    if (obs_a.size() != 0 || ram_cs !== 1'b0) begin
      n_err++;
      $display("FAIL len0_cs got %0d cs cycles want 0", obs_a.size());
    end
    handshake();
  endtask

  task automatic test_wrap;
    int cyc;
    bit to;
    longint e;
    put(32'h7FFE, 2); put(32'h7FFF, -3); put(32'h0000, 5); put(32'h0001, 7);
    put(32'h300, 1);  put(32'h301, 2);   put(32'h302, 3);  put(32'h303, 4);
    start_op(32'h7FFE, 32'h300, 4, 1'b1);
    wait_valid(cyc, to);
    e = exp_q.pop_front();
    void'(exp16_q.pop_front());
    n_vec++;
    if (to || longint'($signed(result)) != e || e != 39) begin
      n_err++;
      $display("FAIL wrap_result got %0d timeout=%0d want %0d", $signed(result), to, e);
    end
    for (int i = 0; i < 4 && i < obs_a.size(); i++) begin
      n_vec++;
      if (obs_a[i] != ((32'h7FFE + i) & 32'h7FFF)) begin
        n_err++;
        $display("FAIL wrap_addr[%0d] got %h want %h", i, obs_a[i], (32'h7FFE + i) & 32'h7FFF);
      end
    end
    handshake();
  endtask

  task automatic test_saturation;
    int cyc;
    bit to;
    longint e, e16;
    int wb[3] = '{32'h1000, 32'h1000, 32'h1300};
    int xb[3] = '{32'h1100, 32'h1200, 32'h1400};
    longint want16[3] = '{32767, -32768, 16511};
    for (int i = 0; i < 4; i++) begin
      put(32'h1000 + i, 127);
      put(32'h1100 + i, 127);
      put(32'h1200 + i, -128);
      put(32'h1300 + i, (i == 3) ? -128 : 127);
      put(32'h1400 + i, 127);
    end
    for (int k = 0; k < 3; k++) begin
      start_op(wb[k], xb[k], 4, 1'b1);
      wait_valid(cyc, to);
      e = exp_q.pop_front();
      e16 = exp16_q.pop_front();
      n_vec++;
      if (to || longint'($signed(result_16)) != e16 || e16 != want16[k]) begin
        n_err++;
        $display("FAIL sat16[%0d] got %0d want %0d", k, $signed(result_16), want16[k]);
      end
      n_vec++;
      if (longint'($signed(result)) != e) begin
        n_err++;
        $display("FAIL sat24[%0d] got %0d want %0d", k, $signed(result), e);
      end
      handshake();
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit to;
    longint e;
    logic [23:0] held;
    start_op(32'h10, 32'h200, 4, 1'b1);
    wait_valid(cyc, to);
    e = exp_q.pop_front();
    void'(exp16_q.pop_front());
    held = result;
    for (int c = 0; c < 10; c++) begin
      start = (c == 3);
      w_base = AW'(32'h40);
      len    = LW'(1);
      n_vec++;
      if (result_valid !== 1'b1 || result !== held || longint'($signed(result)) != e) begin
        n_err++;
        $display("FAIL hold_stable[%0d] got vld=%b result=%h want 1/%h", c, result_valid, result, held);
      end
      tick();
    end
    start = 1'b0;
    handshake();
    n_vec++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL hold_release got busy=%b vld=%b want 0/0", busy, result_valid);
    end
    start_op(32'h40, 32'h240, 1, 1'b1);
    wait_valid(cyc, to);
    e = exp_q.pop_front();
    void'(exp16_q.pop_front());
    n_vec++;
    if (to || cyc != 3 || longint'($signed(result)) != e) begin
      n_err++;
      $display("FAIL b2b_result got cycle=%0d result=%0d want cycle=3 result=%0d",
               cyc, $signed(result), e);
    end
    handshake();
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit to;
    longint e;
    for (int i = 0; i < 8; i++) begin
      put(32'h2000 + i, 100 - 7 * i);
      put(32'h2100 + i, 50 + i);
    end
    start_op(32'h2000, 32'h2100, 8, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    n_vec++;
    if (busy !== 1'b0 || ram_cs !== 1'b0 || result_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid got busy=%b cs=%b vld=%b want 0/0/0", busy, ram_cs, result_valid);
    end
    rst = 1'b0;
    tick();
    start_op(32'h10, 32'h200, 2, 1'b1);
    wait_valid(cyc, to);
    e = exp_q.pop_front();
    void'(exp16_q.pop_front());
    n_vec++;
    if (to || cyc != 4 || longint'($signed(result)) != e || e != -7) begin
      n_err++;
      $display("FAIL after_reset got cycle=%0d result=%0d want cycle=4 result=%0d",
               cyc, $signed(result), e);
    end
    handshake();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    result_ready = 1'b0;
    w_base = '0;
    x_base = '0;
    len = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 8'h00;
    test_reset();
    test_basic();
    test_extremes();
    test_wrap();
    test_saturation();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spram_dot_reader.md
Name: spram_dot_reader

Overview:
- Read-side master for the dual-read-port single-port weight/activation RAM of the MLP datapath.
- On `start`, it streams `len` weight words from RAM port A and `len` activation words from port B, one pair per cycle.
- It multiplies each pair as signed values and accumulates them into a saturating signed sum.
- It presents the neuron pre-activation result with a valid/ready handshake to the activation stage.

Parameters:
- DATA_WIDTH, 8, RAM word width; operands are two's-complement signed.
- ADDR_WIDTH, 15, RAM address width.
- LEN_WIDTH, 10, width of the vector-length field.
- ACC_WIDTH, 24, accumulator/result width; must be >= 2*DATA_WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- w_base  in  ADDR_WIDTH  first weight address (port A).
- x_base  in  ADDR_WIDTH  first activation address (port B).
- len  in  LEN_WIDTH  number of products to accumulate.
- busy  out  1  high in every state except IDLE.
- result  out  ACC_WIDTH  signed dot product; stable while result_valid is high.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- ram_address_a  out  ADDR_WIDTH  RAM read address A.
- ram_address_b  out  ADDR_WIDTH  RAM read address B.
- ram_cs  out  1  RAM chip select.
- ram_we  out  1  RAM write enable; tied 0.
- ram_oe_a  out  1  RAM output enable A.
- ram_oe_b  out  1  RAM output enable B.
- ram_data_a  in  DATA_WIDTH  RAM data out A.
- ram_data_b  in  DATA_WIDTH  RAM data out B.

Behaviour:
- RAM timing: an address driven in cycle t is registered by the RAM at the closing edge of t. Its data is visible on ram_data_* during cycle t+1, but only while ram_cs=1, ram_oe_*=1 and ram_we=0; otherwise the RAM forces the data to 0.
- Reset: state=IDLE, result=0, result_valid=0, busy=0, ram_cs=0, ram_oe_a=ram_oe_b=0, ram_addresses=0, ram_we=0, internal count and accumulator=0.
- Reset mid-operation abandons the operation immediately; no result is produced.
- FSM states: IDLE, FETCH, DRAIN, HOLD.
- IDLE:
  - On start with len!=0: latch the bases and len, clear the accumulator, go to FETCH.
  - On start with len=0: result=0, go to HOLD.
  - Without start: stay in IDLE.
- FETCH:
  - Drive ram_address_a = w_base+i and ram_address_b = x_base+i for i=0..len-1, one index per cycle; ram_cs=ram_oe_a=ram_oe_b=1.
  - Address arithmetic wraps modulo 2^ADDR_WIDTH.
  - A one-bit pipeline flag marks the cycle after each issue as "data valid".
  - On each data-valid cycle: acc <= sat(acc + sext(signed(ram_data_a) * signed(ram_data_b))).
  - After issuing index len-1, go to DRAIN.
- DRAIN:
  - One cycle. ram_cs and ram_oe_* stay high so the last word is not gated to 0.
  - The last product is accumulated.
  - At the cycle end: result <= final acc, result_valid <= 1, go to HOLD. ram_cs and ram_oe_* drop from HOLD onward.
- HOLD:
  - result_valid=1 and result is stable.
  - When result_valid && result_ready at a rising edge: result_valid <= 0, state <= IDLE. result keeps its value.
- Latency: start accepted in cycle 0 → result_valid high from cycle len+2 (len>=1). For len=0, result_valid is high from cycle 1.
- Back-to-back operation: a new start is accepted in the first IDLE cycle after the handshake; no combinational ready-to-start path.
- Saturation:
  - The sum is computed at ACC_WIDTH+1 bits.
  - Positive overflow clamps to 2^(ACC_WIDTH-1)-1; negative overflow clamps to -2^(ACC_WIDTH-1).
  - Saturation is sticky per step: it is applied each accumulate, not only at the end.
- Ignored inputs:
  - start while busy is ignored.
  - base/len changes after acceptance have no effect.
  - result_ready outside HOLD is ignored.
- ram_we is constant 0 in every state.

Test Plan:
- w_base=0x10, x_base=0x200, len=4; weights {1,-2,3,4}, activations {5,6,-7,8} → result=5-12-21+32=4 (0x000004); result_valid rises in cycle 6; addresses 0x10..0x13 and 0x200..0x203 are observed.
- len=1; w=-128, x=-128 → result=16384. Then len=0 → result=0 and result_valid in cycle 1, with ram_cs never asserted.
- w_base=0x7FFE, len=4 → port A addresses 0x7FFE, 0x7FFF, 0x0000, 0x0001; the correct sum proves wrap-around.
- ACC_WIDTH=16, len=4, all w=x=127 (16129 each) → result clamps to 32767. All w=127, x=-128 → result=-32768.
- Hold result_ready=0 for 10 cycles → result_valid and result stay stable and a start pulse is ignored. Ready then goes high → IDLE next cycle, and a new start is accepted.
- Assert rst during FETCH of a len=8 run → the next cycle shows IDLE, busy=0, ram_cs=0, result_valid=0. A fresh len=2 run then yields the correct result with no residue in the accumulator.
